// File: rtl/idli_pkg.sv
// Shared idli types: SQI controller states, commands and word-address type.
package idli_pkg;

    localparam int SQI_NUM = 2;

    typedef logic [3:0]  sqi_data_t;
    typedef logic [15:0] word_addr_t;
    typedef logic [2:0]  sqi_state_t;

    typedef enum logic {
        MEM_LO = 1'b0,
        MEM_HI = 1'b1
    } sqi_mem_t;

    localparam sqi_state_t SQI_IDLE  = 3'd0;
    localparam sqi_state_t SQI_CMD   = 3'd1;
    localparam sqi_state_t SQI_ADDR  = 3'd2;
    localparam sqi_state_t SQI_DUMMY = 3'd3;
    localparam sqi_state_t SQI_DATA  = 3'd4;
    localparam sqi_state_t SQI_GAP   = 3'd5;
    localparam sqi_state_t SQI_WDATA = 3'd6;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // Command byte followed by the 24-bit byte address, MSB nibble first.
    function automatic logic [31:0] sqi_seq(input logic [7:0] cmd, input word_addr_t addr);
        return {cmd, 8'h00, addr};
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl.sv
// Instruction fetch over two x4 SQI memories sharing CS/SCK, one 16-bit word per two data nibbles.
// Optional write path enabled by defining IDLI_SQI_WRITE_EN.
module idli_sqi_ctrl
    import idli_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef IDLI_SQI_WRITE_EN
    input  logic              i_wr_vld,
    output logic              o_wr_rdy,
    input  logic [15:0]       i_wr_addr,
    input  logic [15:0]       i_wr_data,
`endif
    input  logic              i_redir_vld,
    input  logic [15:0]       i_redir_addr,
    output logic              o_word_vld,
    input  logic              i_word_rdy,
    output logic [15:0]       o_word,
    output logic              o_sqi_cs_n,
    output logic              o_sqi_sck_en,
    output logic              o_sqi_oe,
    output logic [1:0][3:0]   o_sqi_out,
    input  logic [1:0][3:0]   i_sqi_in,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a word transfers in any cycle where o_word_vld && i_word_rdy.
    sqi_state_t state;
    logic [2:0] cnt;
    word_addr_t addr;
    logic [7:0] up_q;
    logic       word_vld;
    logic [15:0] word;
    logic       phase1_adv;
    logic [31:0] seq;
    sqi_data_t  cmd_nib;

`ifdef IDLI_SQI_WRITE_EN
    logic       wr_mode;
    logic       resume;
    word_addr_t wr_addr;
    logic [15:0] wr_data;
    logic       wr_acc;

    assign o_wr_rdy = (state == SQI_IDLE) || (state == SQI_DATA && !cnt[0]);
    assign wr_acc   = i_wr_vld && o_wr_rdy;
`endif

    assign phase1_adv  = !word_vld || i_word_rdy;
    assign o_word_vld  = word_vld;
    assign o_word      = word;
    assign o_dbg_state = state;

    always_comb begin
`ifdef IDLI_SQI_WRITE_EN
        seq = wr_mode ? sqi_seq(SQI_CMD_WRITE, wr_addr) : sqi_seq(SQI_CMD_READ, addr);
`else
        seq = sqi_seq(SQI_CMD_READ, addr);
`endif
        // cnt runs 0..7 across CMD and ADDR, selecting nibbles from the MSB down.
        cmd_nib = seq[{~cnt, 2'b00} +: 4];
    end

    always_comb begin
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        o_sqi_oe     = 1'b0;
        o_sqi_out    = '0;
        case (state)
            SQI_CMD, SQI_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_oe     = 1'b1;
                o_sqi_out    = {cmd_nib, cmd_nib};
            end
            SQI_DUMMY: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
            end
            SQI_DATA: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = !cnt[0] || phase1_adv;
            end
`ifdef IDLI_SQI_WRITE_EN
            SQI_WDATA: begin
                o_sqi_cs_n        = 1'b0;
                o_sqi_sck_en      = 1'b1;
                o_sqi_oe          = 1'b1;
                o_sqi_out[MEM_LO] = cnt[0] ? wr_data[3:0] : wr_data[11:8];
                o_sqi_out[MEM_HI] = cnt[0] ? wr_data[7:4] : wr_data[15:12];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= SQI_IDLE;
            cnt      <= '0;
            addr     <= '0;
            up_q     <= '0;
            word_vld <= 1'b0;
            word     <= '0;
`ifdef IDLI_SQI_WRITE_EN
            wr_mode  <= 1'b0;
            resume   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`endif
        end else begin
            if (i_word_rdy) word_vld <= 1'b0;
            case (state)
                SQI_CMD, SQI_ADDR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd1) state <= SQI_ADDR;
                    if (cnt == 3'd7) begin
                        cnt <= '0;
`ifdef IDLI_SQI_WRITE_EN
                        state <= wr_mode ? SQI_WDATA : SQI_DUMMY;
`else
                        state <= SQI_DUMMY;
`endif
                    end
                end
                SQI_DUMMY: begin
                    cnt <= cnt + 3'd1;
                    if (cnt[0]) begin
                        cnt   <= '0;
                        state <= SQI_DATA;
                    end
                end
                SQI_DATA: begin
                    if (!cnt[0]) begin
                        up_q <= {i_sqi_in[MEM_HI], i_sqi_in[MEM_LO]};
                        cnt  <= 3'd1;
                    end else if (phase1_adv) begin
                        word     <= {up_q, i_sqi_in[MEM_HI], i_sqi_in[MEM_LO]};
                        word_vld <= 1'b1;
                        addr     <= addr + 16'd1;
                        cnt      <= '0;
                        // Byte address 0x010000 is not ours; restart the burst at 0.
                        if (addr == 16'hFFFF) state <= SQI_GAP;
                    end
                end
                SQI_GAP: begin
                    cnt <= '0;
`ifdef IDLI_SQI_WRITE_EN
                    state <= (wr_mode || resume) ? SQI_CMD : SQI_IDLE;
`else
                    state <= SQI_CMD;
`endif
                end
`ifdef IDLI_SQI_WRITE_EN
                SQI_WDATA: begin
                    cnt <= cnt + 3'd1;
                    if (cnt[0]) begin
                        cnt     <= '0;
                        wr_mode <= 1'b0;
                        state   <= SQI_GAP;
                    end
                end
`endif
                default: ;
            endcase

`ifdef IDLI_SQI_WRITE_EN
            if (wr_acc) begin
                wr_mode <= 1'b1;
                wr_addr <= i_wr_addr;
                wr_data <= i_wr_data;
                cnt     <= '0;
                state   <= (state == SQI_IDLE) ? SQI_CMD : SQI_GAP;
            end
            // During a write a redirect only retargets where reading resumes.
            if (i_redir_vld) begin
                addr     <= i_redir_addr;
                resume   <= 1'b1;
                word_vld <= 1'b0;
                if (!wr_mode && !wr_acc) begin
                    cnt   <= '0;
                    state <= (state == SQI_IDLE) ? SQI_CMD : SQI_GAP;
                end
            end
`else
            if (i_redir_vld) begin
                addr     <= i_redir_addr;
                word_vld <= 1'b0;
                cnt      <= '0;
                state    <= (state == SQI_IDLE) ? SQI_CMD : SQI_GAP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Directed bench for idli_sqi_ctrl: table of read streams plus hand sequences; the
// write scenario is built when IDLI_SQI_WRITE_EN is defined.
module tb_idli_sqi_ctrl;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_redir_vld = 1'b0;
    logic [15:0]       i_redir_addr = '0;
    logic              o_word_vld;
    logic              i_word_rdy = 1'b0;
    logic [15:0]       o_word;
    logic              o_sqi_cs_n;
    logic              o_sqi_sck_en;
    logic              o_sqi_oe;
    logic [1:0][3:0]   o_sqi_out;
    logic [1:0][3:0]   i_sqi_in = '0;
    logic [2:0]        o_dbg_state;
`ifdef IDLI_SQI_WRITE_EN
    logic              i_wr_vld = 1'b0;
    logic              o_wr_rdy;
    logic [15:0]       i_wr_addr = '0;
    logic [15:0]       i_wr_data = '0;
`endif

    idli_sqi_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
`ifdef IDLI_SQI_WRITE_EN
        .i_wr_vld     (i_wr_vld),
        .o_wr_rdy     (o_wr_rdy),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
`endif
        .i_redir_vld  (i_redir_vld),
        .i_redir_addr (i_redir_addr),
        .o_word_vld   (o_word_vld),
        .i_word_rdy   (i_word_rdy),
        .o_word       (o_word),
        .o_sqi_cs_n   (o_sqi_cs_n),
        .o_sqi_sck_en (o_sqi_sck_en),
        .o_sqi_oe     (o_sqi_oe),
        .o_sqi_out    (o_sqi_out),
        .i_sqi_in     (i_sqi_in),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [31:0] cmd_q[$];
    logic [7:0]  wr_nib_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hABCD : (a ^ 16'h5A5A);
    endfunction

    // Memory BFM: decodes command/address, returns read data nibbles.
    int          nib_cnt = 0;
    logic [31:0] sr = '0;
    logic [15:0] bfm_addr = '0;
    always @(negedge i_clk) begin
        #1;
        if (o_sqi_cs_n) begin
            nib_cnt = 0;
        end else if (o_sqi_sck_en) begin
            if (nib_cnt < 8) begin
                check("nibbles_identical", {24'h0, o_sqi_out[1]}, {24'h0, o_sqi_out[0]});
                sr = {sr[27:0], o_sqi_out[0]};
                if (nib_cnt == 7) begin
                    cmd_q.push_back(sr);
                    bfm_addr = sr[15:0];
                end
            end else if (sr[31:24] == 8'h03 && nib_cnt >= 10) begin
                int k;
                logic [15:0] w;
                k = nib_cnt - 10;
                w = mem_word(bfm_addr + 16'(k / 2));
                i_sqi_in[0] = k[0] ? w[3:0] : w[11:8];
                i_sqi_in[1] = k[0] ? w[7:4] : w[15:12];
            end else if (sr[31:24] == 8'h02 && nib_cnt >= 8) begin
                wr_nib_q.push_back({o_sqi_out[1], o_sqi_out[0]});
            end
            nib_cnt++;
        end
    end

    // Consumer monitor
    always @(negedge i_clk) begin
        #1;
        if (o_word_vld && i_word_rdy) got_q.push_back(o_word);
    end

    // driver tasks
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_redir_vld = 1'b0;
        repeat (2) step();
        i_rst = 1'b0;
        got_q.delete();
        cmd_q.delete();
        wr_nib_q.delete();
    endtask

    task automatic redirect(input logic [15:0] a);
        i_redir_vld  = 1'b1;
        i_redir_addr = a;
        step();
        i_redir_vld  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int b;
        b = 0;
        while (got_q.size() < n && b < 400) begin
            step();
            b++;
        end
        check("word_timeout", {31'h0, got_q.size() >= n}, 32'h1);
    endtask

    typedef struct {
        logic [15:0]       start;
        int                stall;
        logic [2:0][15:0]  exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0].start = 16'h1234; vecs[0].stall = 0;
        vecs[0].exp   = {16'h486C, 16'h486F, 16'hABCD};
        vecs[1].start = 16'h0040; vecs[1].stall = 30;
        vecs[1].exp   = {16'h5A18, 16'h5A1B, 16'h5A1A};
        vecs[2].start = 16'h0008; vecs[2].stall = 0;
        vecs[2].exp   = {16'h5A50, 16'h5A53, 16'h5A52};
        vecs[3].start = 16'hFFFE; vecs[3].stall = 0;
        vecs[3].exp   = {16'h5A5A, 16'hA5A5, 16'hA5A4};

        // Reset state
        do_reset();
        check("rst_cs_n",   {31'h0, o_sqi_cs_n},   32'h1);
        check("rst_oe",     {31'h0, o_sqi_oe},     32'h0);
        check("rst_sck_en", {31'h0, o_sqi_sck_en}, 32'h0);
        check("rst_vld",    {31'h0, o_word_vld},   32'h0);
        check("rst_word",   {16'h0, o_word},       32'h0);
        check("rst_out",    {24'h0, o_sqi_out},    32'h0);
        check("rst_state",  {29'h0, o_dbg_state},  32'h0);

        // First-word latency: valid rises 13 cycles after the redirect cycle
        i_word_rdy = 1'b1;
        redirect(16'h1234);
        repeat (11) step();
        check("lat_vld_c12", {31'h0, o_word_vld}, 32'h0);
        step();
        check("lat_vld_c13", {31'h0, o_word_vld}, 32'h1);
        check("lat_word",    {16'h0, o_word},     32'h0000ABCD);
        check("lat_cmd",     cmd_q.size() > 0 ? cmd_q[0] : 32'hX, 32'h03001234);

        // Table of read streams
        for (int v = 0; v < 4; v++) begin
            do_reset();
            i_word_rdy = (vecs[v].stall == 0);
            redirect(vecs[v].start);
            if (vecs[v].stall > 0) begin
                repeat (vecs[v].stall) step();
                check("stall_sck_en", {31'h0, o_sqi_sck_en}, 32'h0);
                check("stall_vld",    {31'h0, o_word_vld},   32'h1);
                check("stall_word",   {16'h0, o_word},       {16'h0, vecs[v].exp[0]});
                i_word_rdy = 1'b1;
            end
            for (int i = 0; i < 3; i++) exp_q.push_back(vecs[v].exp[i]);
            wait_words(3);
            for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
                check($sformatf("vec%0d_word%0d", v, i), {16'h0, got_q.pop_front()}, {16'h0, exp_q.pop_front()});
            end
            exp_q.delete();
            check($sformatf("vec%0d_cmd", v), cmd_q.size() > 0 ? cmd_q[0] : 32'hX, {16'h0300, vecs[v].start});
            if (vecs[v].start == 16'hFFFE) begin
                check("wrap_cmd_count", cmd_q.size(), 32'd2);
                check("wrap_cmd",       cmd_q.size() > 1 ? cmd_q[1] : 32'hX, 32'h03000000);
            end
        end

        // Redirect in the middle of ADDR
        do_reset();
        i_word_rdy = 1'b1;
        redirect(16'h1234);
        repeat (2) step();
        check("mid_in_addr", {29'h0, o_dbg_state}, 32'h2);
        redirect(16'h0040);
        check("mid_gap_cs_n", {31'h0, o_sqi_cs_n}, 32'h1);
        check("mid_gap_vld",  {31'h0, o_word_vld}, 32'h0);
        step();
        check("mid_cmd_cs_n", {31'h0, o_sqi_cs_n}, 32'h0);
        check("mid_cmd_oe",   {31'h0, o_sqi_oe},   32'h1);
        wait_words(1);
        check("mid_first_word", {16'h0, got_q.size() > 0 ? got_q[0] : 16'hXXXX}, 32'h00005A1A);
        check("mid_cmd", cmd_q.size() > 0 ? cmd_q[0] : 32'hX, 32'h03000040);

        // Reset during a stalled DATA phase 1 with a word pending
        do_reset();
        i_word_rdy = 1'b0;
        redirect(16'h0008);
        repeat (13) step();
        check("rstmid_pre_vld", {31'h0, o_word_vld}, 32'h1);
        i_rst = 1'b1;
        step();
        check("rstmid_cs_n",  {31'h0, o_sqi_cs_n},  32'h1);
        check("rstmid_vld",   {31'h0, o_word_vld},  32'h0);
        check("rstmid_state", {29'h0, o_dbg_state}, 32'h0);

        // Redirect held during reset is not honoured
        i_redir_vld  = 1'b1;
        i_redir_addr = 16'h0100;
        repeat (2) step();
        i_rst = 1'b0;
        i_redir_vld = 1'b0;
        step();
        check("rstredir_state", {29'h0, o_dbg_state}, 32'h0);
        check("rstredir_cs_n",  {31'h0, o_sqi_cs_n},  32'h1);

`ifdef IDLI_SQI_WRITE_EN
        // Write while streaming; reading resumes at the next unfetched word
        do_reset();
        i_word_rdy = 1'b1;
        redirect(16'h0008);
        wait_words(1);
        begin
            int b;
            b = 0;
            while (!o_wr_rdy && b < 20) begin
                step();
                b++;
            end
            check("wr_rdy_timeout", {31'h0, o_wr_rdy}, 32'h1);
        end
        i_wr_vld  = 1'b1;
        i_wr_addr = 16'h0010;
        i_wr_data = 16'h5A3C;
        step();
        i_wr_vld  = 1'b0;
        wait_words(4);
        check("wr_cmd", cmd_q.size() > 1 ? cmd_q[1] : 32'hX, 32'h02000010);
        check("wr_nib_count", wr_nib_q.size(), 32'd2);
        check("wr_nib0", {24'h0, wr_nib_q.size() > 0 ? wr_nib_q[0] : 8'hXX}, 32'h5A);
        check("wr_nib1", {24'h0, wr_nib_q.size() > 1 ? wr_nib_q[1] : 8'hXX}, 32'h3C);
        exp_q.push_back(16'h5A52);
        exp_q.push_back(16'h5A53);
        exp_q.push_back(16'h5A50);
        exp_q.push_back(16'h5A51);
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            check($sformatf("wr_resume_word%0d", i), {16'h0, got_q.pop_front()}, {16'h0, exp_q.pop_front()});
        end
        exp_q.delete();
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
